// File: rtl/wb_queue.sv
// Writeback queue: buffers up to three results per cycle and drains two per cycle to the register file.
// Optional forwarding to the operand read ports is built when WBQ_FWD_EN is defined.
module wb_queue #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  input  logic [1:0][4:0]  in_addr,
  input  logic [1:0][31:0] in_data,
  output logic             in_ready,
  input  logic             ll_valid,
  input  logic [4:0]       ll_addr,
  input  logic [31:0]      ll_data,
  output logic             ll_ready,
  input  logic             drain_en,
  output logic [1:0]       write_ena,
  output logic [1:0][4:0]  write_addr,
  output logic [1:0][31:0] write_data,
  input  logic [3:0][4:0]  fwd_addr,
  output logic [3:0]       fwd_hit,
  output logic [3:0][31:0] fwd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] head_nx_s;
  logic [AW-1:0] wr_ptr_s;
  logic [1:0]    pops_s;
  logic [1:0]    pipe_used_s;
  logic [1:0]    pushes_s;
  logic [CW-1:0] free_s;
  logic [1:0]    lane_push_s;
  logic          ll_push_s;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return 2'(v[0]) + 2'(v[1]);
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  // Drain the two oldest entries; suppressed while reset is asserted.
  always_comb begin
    write_ena = 2'b00;
    head_nx_s = head_q + AW'(1);
    if (!rst && drain_en) begin
      write_ena[0] = (count_q >= CW'(1));
      write_ena[1] = (count_q >= CW'(2));
    end else begin
      write_ena = 2'b00;
    end
    write_addr[0] = addr_q[head_q];
    write_data[0] = data_q[head_q];
    write_addr[1] = addr_q[head_nx_s];
    write_data[1] = data_q[head_nx_s];
  end

  // Space accounting: slots freed by this cycle's pops are reusable now.
  always_comb begin
    pops_s      = popcount2(write_ena);
    free_s      = CW'(DEPTH) - count_q + CW'(pops_s);
    in_ready    = (free_s >= CW'(2));
    lane_push_s = in_valid & {2{in_ready}} &
                  {(in_addr[1] != 5'd0), (in_addr[0] != 5'd0)};
    pipe_used_s = popcount2(lane_push_s);
    ll_ready    = ((free_s - CW'(pipe_used_s)) >= CW'(1));
    ll_push_s   = ll_valid & ll_ready & (ll_addr != 5'd0);
    pushes_s    = popcount3({ll_push_s, lane_push_s});
  end

  // Enqueue lane 0, lane 1, then the long-latency result into consecutive slots.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_s = tail_q;
    for (int i = 0; i < 2; i++) begin
      addr_d[wr_ptr_s] = lane_push_s[i] ? in_addr[i] : addr_d[wr_ptr_s];
      data_d[wr_ptr_s] = lane_push_s[i] ? in_data[i] : data_d[wr_ptr_s];
      wr_ptr_s         = wr_ptr_s + AW'(lane_push_s[i]);
    end
    addr_d[wr_ptr_s] = ll_push_s ? ll_addr : addr_d[wr_ptr_s];
    data_d[wr_ptr_s] = ll_push_s ? ll_data : data_d[wr_ptr_s];
    wr_ptr_s         = wr_ptr_s + AW'(ll_push_s);
    tail_d  = wr_ptr_s;
    head_d  = head_q + AW'(pops_s);
    count_d = count_q - CW'(pops_s) + CW'(pushes_s);
  end

  // Entry storage is left untouched by reset; occupancy comes from count.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef WBQ_FWD_EN
  // Scan oldest to youngest so the last occupied match is the youngest.
  always_comb begin
    logic [AW-1:0] idx;
    logic          match;
    fwd_hit  = '0;
    fwd_data = '0;
    idx      = '0;
    match    = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx         = head_q + AW'(k);
        match       = (fwd_addr[p] != 5'd0) && (CW'(k) < count_q) &&
                      (addr_q[idx] == fwd_addr[p]);
        fwd_hit[p]  = fwd_hit[p] | match;
        fwd_data[p] = match ? data_q[idx] : fwd_data[p];
      end
    end
  end
`else
  logic fwd_addr_unused_s;
  assign fwd_addr_unused_s = ^fwd_addr;
  assign fwd_hit  = '0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed testbench for wb_queue (DEPTH=8); forwarding expectations follow WBQ_FWD_EN.
module tb_wb_queue;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_valid;
  logic [1:0][4:0]  in_addr;
  logic [1:0][31:0] in_data;
  logic             in_ready;
  logic             ll_valid;
  logic [4:0]       ll_addr;
  logic [31:0]      ll_data;
  logic             ll_ready;
  logic             drain_en;
  logic [1:0]       write_ena;
  logic [1:0][4:0]  write_addr;
  logic [1:0][31:0] write_data;
  logic [3:0][4:0]  fwd_addr;
  logic [3:0]       fwd_hit;
  logic [3:0][31:0] fwd_data;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef WBQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .ll_valid(ll_valid), .ll_addr(ll_addr), .ll_data(ll_data), .ll_ready(ll_ready),
    .drain_en(drain_en),
    .write_ena(write_ena), .write_addr(write_addr), .write_data(write_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  // Register file model: port 1 is written last, so it wins on equal addresses.
  always @(posedge clk) begin
    if (write_ena[0]) rf[write_addr[0]] <= write_data[0];
    if (write_ena[1]) rf[write_addr[1]] <= write_data[1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    in_valid   = v;
    in_addr[0] = a0;
    in_addr[1] = a1;
    in_data[0] = d0;
    in_data[1] = d1;
  endtask

  task automatic ll(input logic v, input logic [4:0] a, input logic [31:0] d);
    ll_valid = v;
    ll_addr  = a;
    ll_data  = d;
  endtask

  task automatic expect_drain(input string tag, input logic [1:0] ena,
                              input logic [4:0] a0, input logic [4:0] a1);
    check({tag, "_ena"}, 64'(write_ena), 64'(ena));
    if (ena[0]) check({tag, "_a0"}, 64'(write_addr[0]), 64'(a0));
    if (ena[1]) check({tag, "_a1"}, 64'(write_addr[1]), 64'(a1));
  endtask

  initial begin
    rst = 1'b1;
    pair(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    ll(1'b0, 5'd0, 32'h0);
    drain_en = 1'b0;
    fwd_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_ena", 64'(write_ena), 64'h0);
    check("rst_hit", 64'(fwd_hit), 64'h0);
    check("rst_fdata", 64'(fwd_data[0]), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_ll_ready", 64'(ll_ready), 64'h1);

    // Basic accept and drain
    pair(2'b11, 5'd5, 5'd6, 32'h11, 32'h22);
    drain_en = 1'b1;
    tick();
    pair(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    expect_drain("basic", 2'b11, 5'd5, 5'd6);
    check("basic_d0", 64'(write_data[0]), 64'h11);
    check("basic_d1", 64'(write_data[1]), 64'h22);
    tick();
    check("basic_empty", 64'(write_ena), 64'h0);

    // Fill and block
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pair(2'b11, 5'(2*i+1), 5'(2*i+2), 32'((2*i+1) << 8), 32'((2*i+2) << 8));
      tick();
    end
    pair(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    check("full_in_ready", 64'(in_ready), 64'h0);
    check("full_ll_ready", 64'(ll_ready), 64'h0);
    check("full_noena", 64'(write_ena), 64'h0);
    drain_en = 1'b1;
    #1;
    check("full_drain_in_ready", 64'(in_ready), 64'h1);
    expect_drain("fill0", 2'b11, 5'd1, 5'd2);
    check("fill0_d0", 64'(write_data[0]), 64'h100);
    tick();
    expect_drain("fill1", 2'b11, 5'd3, 5'd4);
    tick();
    expect_drain("fill2", 2'b11, 5'd5, 5'd6);
    tick();
    expect_drain("fill3", 2'b11, 5'd7, 5'd8);
    check("fill3_d1", 64'(write_data[1]), 64'h800);
    tick();
    check("fill_empty", 64'(write_ena), 64'h0);

    // Long-latency priority at count = DEPTH-2
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pair(2'b11, 5'(2*i+1), 5'(2*i+2), 32'h0, 32'h0);
      tick();
    end
    pair(2'b11, 5'd9, 5'd10, 32'h9, 32'hA);
    ll(1'b1, 5'd12, 32'hCC);
    #1;
    check("llp_in_ready", 64'(in_ready), 64'h1);
    check("llp_ll_ready", 64'(ll_ready), 64'h0);
    tick();
    pair(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    check("llp_full_ll_ready", 64'(ll_ready), 64'h0);
    drain_en = 1'b1;
    #1;
    check("llp_drain_ll_ready", 64'(ll_ready), 64'h1);
    check("llp_drain_in_ready", 64'(in_ready), 64'h1);
    expect_drain("llp0", 2'b11, 5'd1, 5'd2);
    tick();
    ll(1'b0, 5'd0, 32'h0);
    #1;
    expect_drain("llp1", 2'b11, 5'd3, 5'd4);
    tick();
    expect_drain("llp2", 2'b11, 5'd5, 5'd6);
    tick();
    expect_drain("llp3", 2'b11, 5'd9, 5'd10);
    tick();
    expect_drain("llp4", 2'b01, 5'd12, 5'd0);
    check("llp4_d0", 64'(write_data[0]), 64'hCC);
    tick();
    check("llp_empty", 64'(write_ena), 64'h0);

    // Count = DEPTH-1 with drain_en low; ll entries follow the pair in order
    drain_en = 1'b0;
    pair(2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
    ll(1'b1, 5'd3, 32'h3);
    tick();
    pair(2'b11, 5'd4, 5'd5, 32'h4, 32'h5);
    ll(1'b1, 5'd6, 32'h6);
    tick();
    pair(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    ll(1'b1, 5'd7, 32'h7);
    tick();
    ll(1'b0, 5'd0, 32'h0);
    #1;
    check("c7_in_ready", 64'(in_ready), 64'h0);
    check("c7_ll_ready", 64'(ll_ready), 64'h1);
    drain_en = 1'b1;
    #1;
    expect_drain("c7_0", 2'b11, 5'd1, 5'd2);
    tick();
    expect_drain("c7_1", 2'b11, 5'd3, 5'd4);
    tick();
    expect_drain("c7_2", 2'b11, 5'd5, 5'd6);
    tick();
    expect_drain("c7_3", 2'b01, 5'd7, 5'd0);
    tick();
    check("c7_empty", 64'(write_ena), 64'h0);

    // Register zero is accepted but not enqueued
    drain_en = 1'b0;
    pair(2'b11, 5'd0, 5'd7, 32'h5, 32'h77);
    fwd_addr[0] = 5'd0;
    fwd_addr[1] = 5'd7;
    tick();
    pair(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    check("r0_hit0", 64'(fwd_hit[0]), 64'h0);
    check("r0_hit1", 64'(fwd_hit[1]), 64'(FWD));
    drain_en = 1'b1;
    #1;
    expect_drain("r0", 2'b01, 5'd7, 5'd0);
    check("r0_d0", 64'(write_data[0]), 64'h77);
    tick();
    check("r0_empty", 64'(write_ena), 64'h0);
    fwd_addr = '0;

    // Forwarding picks the youngest buffered match
    drain_en = 1'b0;
    fwd_addr[2] = 5'd9;
    fwd_addr[3] = 5'd9;
    pair(2'b11, 5'd9, 5'd9, 32'hA, 32'hB);
    #1;
    check("fwd_not_yet", 64'(fwd_hit[2]), 64'h0);
    tick();
    pair(2'b01, 5'd9, 5'd0, 32'hC, 32'h0);
    #1;
    check("fwd_hit_b", 64'(fwd_hit[2]), 64'(FWD));
    check("fwd_data_b", 64'(fwd_data[2]), FWD ? 64'hB : 64'h0);
    tick();
    pair(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    check("fwd_data_c", 64'(fwd_data[3]), FWD ? 64'hC : 64'h0);
    drain_en = 1'b1;
    #1;
    expect_drain("fwd_dr0", 2'b11, 5'd9, 5'd9);
    check("fwd_during_drain", 64'(fwd_data[2]), FWD ? 64'hC : 64'h0);
    tick();
    expect_drain("fwd_dr1", 2'b01, 5'd9, 5'd0);
    check("fwd_last_cycle", 64'(fwd_hit[3]), 64'(FWD));
    tick();
    check("fwd_gone", 64'(fwd_hit), 64'h0);
    fwd_addr = '0;

    // Same-address drain, then reset with entries still queued
    drain_en = 1'b0;
    pair(2'b11, 5'd3, 5'd3, 32'h1, 32'h2);
    tick();
    pair(2'b11, 5'd4, 5'd5, 32'h44, 32'h55);
    tick();
    pair(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    drain_en = 1'b1;
    #1;
    expect_drain("same", 2'b11, 5'd3, 5'd3);
    tick();
    check("same_rf3", 64'(rf[3]), 64'h2);
    rst = 1'b1;
    #1;
    check("rst_cycle_ena", 64'(write_ena), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ena", 64'(write_ena), 64'h0);
    check("post_rst_in_ready", 64'(in_ready), 64'h1);
    check("post_rst_ll_ready", 64'(ll_ready), 64'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
